// File: rtl/pio_pkg.sv
// Shared definitions for the PCIe PIO BAR0 register bank: window codes,
// register indices and the byte-lane helpers used on both write and read paths.
package pio_pkg;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_BAR0 = 2'b01,
        WIN_BAR2 = 2'b10,
        WIN_ROM  = 2'b11
    } pio_win_e;

    localparam int REG_ID       = 0;
    localparam int REG_CTRL     = 1;
    localparam int REG_STAT     = 2;
    localparam int REG_EVT      = 3;
    localparam int REG_CNT_LO   = 4;
    localparam int REG_CNT_HI   = 5;
    localparam int REG_EVT_MASK = 6;
    localparam int REG_CTRL_SET = 7;
    localparam int REG_SCRATCH0 = 8;

    // Bus word <-> register word. With swap set, register byte k travels on
    // bus bits [31-8k -: 8]; the mapping is its own inverse.
    function automatic logic [31:0] lane_map(input logic [31:0] word, input bit swap);
        return swap ? {word[7:0], word[15:8], word[23:16], word[31:24]} : word;
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [31:0] mask);
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/pio_evt_flags.sv
// Sticky event flags with write-1-to-clear, a per-flag enable mask and a
// registered level interrupt.
module pio_evt_flags
    import pio_pkg::*;
#(
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic [EVT_W-1:0] evt_in,
    input  logic             clr_we,
    input  logic             mask_we,
    input  logic [EVT_W-1:0] wr_bits,
    input  logic [EVT_W-1:0] wr_bmask,
    output logic [EVT_W-1:0] flags,
    output logic [EVT_W-1:0] mask,
    output logic             irq
);

    logic [EVT_W-1:0] flag_q, flag_d;
    logic [EVT_W-1:0] mask_q, mask_d;
    logic [EVT_W-1:0] clr_bits;
    logic             irq_q, irq_d;

    always_comb begin
        clr_bits = '0;
        if (clr_we) begin
            clr_bits = wr_bits & wr_bmask;
        end
        // A new event in the same cycle as its clear keeps the flag set.
        flag_d = (flag_q & ~clr_bits) | evt_in;

        mask_d = mask_q;
        if (mask_we) begin
            mask_d = (mask_q & ~wr_bmask) | (wr_bits & wr_bmask);
        end

        irq_d = |(flag_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            flag_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign flags = flag_q;
    assign mask  = mask_q;
    assign irq   = irq_q;

endmodule

// File: rtl/pio_reg_bank.sv
// BAR0 register bank for the PCIe PIO endpoint: ID/CTRL/STAT, event flags,
// 64-bit cycle counter with snapshot, scratch registers and a ROM read window.
module pio_reg_bank
    import pio_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter int          CTRL_W    = 8,
    parameter int          STAT_W    = 4,
    parameter int          EVT_W     = 8,
    parameter logic [31:0] ID_RESET  = 32'h0123_4567,
    parameter bit          BYTE_SWAP = 1'b1
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              rd_en,
    input  logic [13:0]       rd_addr,
    input  logic [3:0]        rd_be,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [13:0]       wr_addr,
    input  logic [7:0]        wr_be,
    input  logic [31:0]       wr_data,
    output logic              wr_busy,
    output logic              rom_en,
    output logic [8:0]        rom_addr,
    input  logic [31:0]       rom_data,
    input  logic [STAT_W-1:0] stat_in,
    input  logic [EVT_W-1:0]  evt_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              irq
);

    localparam int IDX_W = $clog2(NUM_REGS);

    pio_win_e         rd_win, wr_win;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [31:0]      wr_word, wr_mask;
    logic             wr_hit, rd_hit;

    logic [31:0]       id_q, id_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [STAT_W-1:0] stat_meta_q, stat_meta_d;
    logic [STAT_W-1:0] stat_sync_q, stat_sync_d;
    logic [63:0]       cnt_q, cnt_d;
    logic [31:0]       snap_q, snap_d;
    logic [31:0]       scr_q [NUM_REGS];
    logic [31:0]       scr_d [NUM_REGS];

    logic        rd_valid_q, rd_valid_d;
    pio_win_e    rd_win_q, rd_win_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_word;

    logic [EVT_W-1:0] evt_flags, evt_mask;
    logic             evt_clr_we, evt_mask_we;
    logic             unused_ok;

    assign rd_win = pio_win_e'(rd_addr[13:12]);
    assign wr_win = pio_win_e'(wr_addr[13:12]);
    assign rd_idx = rd_addr[IDX_W-1:0];
    assign wr_idx = wr_addr[IDX_W-1:0];
    assign rd_hit = rd_en && (rd_win == WIN_BAR0);
    assign wr_hit = wr_en && (wr_win == WIN_BAR0);

    assign wr_word = lane_map(wr_data, BYTE_SWAP);

    // wr_be[k] gates register byte k; lane_map has already placed it at [8k+:8].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            assign wr_mask[8*gi +: 8] = {8{wr_be[gi]}};
        end
    endgenerate

    assign evt_clr_we  = wr_hit && (wr_idx == IDX_W'(REG_EVT));
    assign evt_mask_we = wr_hit && (wr_idx == IDX_W'(REG_EVT_MASK));

    pio_evt_flags #(
        .EVT_W (EVT_W)
    ) u_evt (
        .clk      (clk),
        .sys_rst_n(sys_rst_n),
        .evt_in   (evt_in),
        .clr_we   (evt_clr_we),
        .mask_we  (evt_mask_we),
        .wr_bits  (wr_word[EVT_W-1:0]),
        .wr_bmask (wr_mask[EVT_W-1:0]),
        .flags    (evt_flags),
        .mask     (evt_mask),
        .irq      (irq)
    );

    // Write side and free-running state.
    always_comb begin
        id_d        = id_q;
        ctrl_d      = ctrl_q;
        scr_d       = scr_q;
        stat_meta_d = stat_in;
        stat_sync_d = stat_meta_q;
        cnt_d       = cnt_q + 64'd1;
        snap_d      = snap_q;

        if (wr_hit) begin
            if (wr_idx == IDX_W'(REG_ID)) begin
                id_d = be_merge(id_q, wr_word, wr_mask);
            end
            if (wr_idx == IDX_W'(REG_CTRL)) begin
                ctrl_d = CTRL_W'(be_merge(32'(ctrl_q), wr_word, wr_mask));
            end
            if (wr_idx == IDX_W'(REG_CTRL_SET)) begin
                ctrl_d = ctrl_q | CTRL_W'(wr_word & wr_mask);
            end
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    scr_d[i] = be_merge(scr_q[i], wr_word, wr_mask);
                end
            end
        end

        // Reading the low half freezes the high half so a later CNT_HI read
        // pairs with it even if the low half wraps in between.
        if (rd_hit && (rd_idx == IDX_W'(REG_CNT_LO))) begin
            snap_d = cnt_q[63:32];
        end
    end

    // Read side: all sources are current flop values, so a same-cycle write
    // is not yet visible.
    always_comb begin
        rd_word = '0;
        if (rd_hit) begin
            if (rd_idx == IDX_W'(REG_ID))       rd_word = id_q;
            if (rd_idx == IDX_W'(REG_CTRL))     rd_word = 32'(ctrl_q);
            if (rd_idx == IDX_W'(REG_STAT))     rd_word = 32'(stat_sync_q);
            if (rd_idx == IDX_W'(REG_EVT))      rd_word = 32'(evt_flags);
            if (rd_idx == IDX_W'(REG_CNT_LO))   rd_word = cnt_q[31:0];
            if (rd_idx == IDX_W'(REG_CNT_HI))   rd_word = snap_q;
            if (rd_idx == IDX_W'(REG_EVT_MASK)) rd_word = 32'(evt_mask);
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rd_word = scr_q[i];
                end
            end
        end
        rdata_d    = lane_map(rd_word, BYTE_SWAP);
        rd_valid_d = rd_en;
        rd_win_d   = rd_win;
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            id_q        <= ID_RESET;
            ctrl_q      <= '0;
            scr_q       <= '{default: '0};
            stat_meta_q <= '0;
            stat_sync_q <= '0;
            cnt_q       <= '0;
            snap_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_win_q    <= WIN_NONE;
            rdata_q     <= '0;
        end else begin
            id_q        <= id_d;
            ctrl_q      <= ctrl_d;
            scr_q       <= scr_d;
            stat_meta_q <= stat_meta_d;
            stat_sync_q <= stat_sync_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            rd_valid_q  <= rd_valid_d;
            rd_win_q    <= rd_win_d;
            rdata_q     <= rdata_d;
        end
    end

    // Gating with reset drops a completion whose request was in flight when
    // reset arrived.
    assign rd_valid = rd_valid_q && sys_rst_n;
    assign rd_data  = !rd_valid          ? 32'd0 :
                      (rd_win_q == WIN_ROM) ? rom_data : rdata_q;

    assign rom_en   = rd_en && (rd_win == WIN_ROM);
    assign rom_addr = rom_en ? rd_addr[8:0] : 9'd0;
    assign wr_busy  = 1'b0;
    assign ctrl_out = ctrl_q;

    assign unused_ok = ^{rd_be, wr_be[7:4], rd_addr[11:9], wr_addr[11:IDX_W]};

endmodule

// File: tb/tb_pio_reg_bank.sv
// Directed bench for pio_reg_bank: read expectations go into a scoreboard
// queue, a monitor pops and compares each rd_valid completion.
module tb_pio_reg_bank;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [3:0]  rd_be;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [7:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_busy;
    logic        rom_en;
    logic [8:0]  rom_addr;
    logic [31:0] rom_data;
    logic [3:0]  stat_in;
    logic [7:0]  evt_in;
    logic [7:0]  ctrl_out;
    logic        irq;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    pio_reg_bank dut (
        .clk      (clk),
        .sys_rst_n(sys_rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_be    (rd_be),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .wr_busy  (wr_busy),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .stat_in  (stat_in),
        .evt_in   (evt_in),
        .ctrl_out (ctrl_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM model: word = A5A5_0000 | address.
    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'hA5A5_0000 | 32'(rom_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        evt_in = '0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue_rd(input logic [13:0] a, input logic [31:0] exp, input string nm);
        rd_en   = 1'b1;
        rd_addr = a;
        rd_be   = 4'hF;
        exp_q.push_back('{data: exp, cyc: cyc + 1, name: nm});
    endtask

    task automatic issue_wr(input logic [13:0] a, input logic [31:0] d, input logic [7:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
    endtask

    // Monitor: every completion must match the head of the scoreboard and
    // arrive exactly one cycle after its request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL %s: rd_valid missing at cycle %0d", e.name, e.cyc);
            end
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rd_valid: got data %h at cycle %0d expected no completion", rd_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (rd_data !== e.data || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL %s: got %h at cycle %0d expected %h at cycle %0d",
                                 e.name, rd_data, cyc, e.data, e.cyc);
                    end else begin
                        $display("rd %s data=%h cycle=%0d", e.name, rd_data, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_be = '0;
        wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        stat_in = 4'hA; evt_in = '0; rom_data = '0;
        repeat (3) tick();

        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data",  64'(rd_data),  64'd0);
        chk("rst_rom_en",   64'(rom_en),   64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_wr_busy",  64'(wr_busy),  64'd0);
        chk("rst_ctrl_out", 64'(ctrl_out), 64'd0);
        chk("rst_irq",      64'(irq),      64'd0);

        sys_rst_n = 1'b1;
        repeat (3) tick();

        // Back-to-back reads of ID, CTRL, STAT and the reset snapshot.
        issue_rd(14'h1000, 32'h6745_2301, "id");        tick();
        issue_rd(14'h1001, 32'h0000_0000, "ctrl_rst");  tick();
        issue_rd(14'h1002, 32'h0A00_0000, "stat");      tick();
        issue_rd(14'h1005, 32'h0000_0000, "cnt_hi_rst"); tick();
        idle();

        // Partial byte write to scratch 8 with a same-cycle read.
        issue_wr(14'h1008, 32'hDEAD_BEEF, 8'h05);
        issue_rd(14'h1008, 32'h0000_0000, "scr8_same_cycle"); tick();
        wr_en = 1'b0;
        issue_rd(14'h1008, 32'hDE00_BE00, "scr8");       tick();
        issue_rd(14'h1018, 32'hDE00_BE00, "scr8_alias"); tick();
        idle();

        // Windows 00 and 10: reads are zero, writes are dropped.
        issue_wr(14'h2008, 32'hFFFF_FFFF, 8'h0F);
        issue_rd(14'h0003, 32'h0000_0000, "win00");      tick();
        wr_en = 1'b0;
        issue_rd(14'h2005, 32'h0000_0000, "win10");      tick();
        issue_rd(14'h1008, 32'hDE00_BE00, "scr8_kept");  tick();
        idle();

        // CTRL write, then CTRL_SET OR-in.
        issue_wr(14'h1001, 32'h5A00_0000, 8'h01); tick(); idle();
        chk("ctrl_write", 64'(ctrl_out), 64'h5A);
        issue_wr(14'h1007, 32'h8100_0000, 8'h01); tick(); idle();
        chk("ctrl_set", 64'(ctrl_out), 64'hDB);
        issue_rd(14'h1001, 32'hDB00_0000, "ctrl_rd");     tick();
        issue_rd(14'h1007, 32'h0000_0000, "ctrl_set_rd"); tick();
        idle();

        // Event flag, mask and interrupt timing.
        evt_in = 8'h08; tick(); evt_in = '0;
        issue_wr(14'h1006, 32'h0800_0000, 8'h01); tick(); idle();
        chk("irq_lag", 64'(irq), 64'd0);
        tick();
        chk("irq_rise", 64'(irq), 64'd1);
        issue_wr(14'h1003, 32'h0800_0000, 8'h01);
        evt_in = 8'h08; tick(); idle();
        tick();
        chk("irq_set_wins", 64'(irq), 64'd1);
        issue_rd(14'h1003, 32'h0800_0000, "evt_set_wins"); tick();
        issue_rd(14'h1006, 32'h0800_0000, "evt_mask");     tick();
        idle();
        issue_wr(14'h1003, 32'h0800_0000, 8'h01); tick(); idle();
        chk("irq_hold", 64'(irq), 64'd1);
        tick();
        chk("irq_fall", 64'(irq), 64'd0);
        issue_rd(14'h1003, 32'h0000_0000, "evt_cleared"); tick();
        idle();

        // Counter snapshot across a low-half wrap.
        force dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
        issue_rd(14'h1004, 32'hFFFF_FFFF, "cnt_lo"); tick();
        release dut.cnt_q;
        issue_rd(14'h1005, 32'h0100_0000, "cnt_hi_snap"); tick();
        idle();

        // ROM window and the window-10 neighbour.
        issue_rd(14'h3005, 32'hA5A5_0005, "rom");
        #1;
        chk("rom_en",   64'(rom_en),   64'd1);
        chk("rom_addr", 64'(rom_addr), 64'd5);
        tick();
        issue_rd(14'h2005, 32'h0000_0000, "win10_after_rom");
        #1;
        chk("rom_en_off", 64'(rom_en), 64'd0);
        tick();
        idle();
        tick();

        // Reset while a read is in flight: its completion must vanish.
        rd_en = 1'b1; rd_addr = 14'h1001; tick();
        rd_en = 1'b0; sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_valid", 64'(rd_valid), 64'd0);
        tick();
        chk("rst_mid_ctrl_out", 64'(ctrl_out), 64'd0);
        sys_rst_n = 1'b1; tick();
        issue_rd(14'h1001, 32'h0000_0000, "ctrl_after_rst"); tick();
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d reads outstanding expected 0", exp_q.size());
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
